bytes_to_bits: RTL and testbench
================================

// Module: bytes_to_bits
// PURPOSE
//   Converts an array of N_BYTES bytes into a flat bit vector, where bit j of byte i
//   maps to flat bit 8*i+j (LSB-first, byte 0 lowest), i.e. the ML-KEM BytesToBits order.
//   Streaming stage with valid/ready on both sides and one register stage.
//   Sits between byte-oriented buffers and bit-oriented decompress/sampling logic.
// PARAMETERS
//   N_BYTES  4  number of bytes per transfer (>=1); output width N_BYTES*8
// PORTS
//   clk_i        in   1            single clock, all state on rising edge
//   rst_i        in   1            synchronous reset, active-high
//   in_valid_i   in   1            bytes_i holds a valid word
//   in_ready_o   out  1            block can accept a word this cycle
//   bytes_i      in   N_BYTES x 8  packed byte array [N_BYTES-1:0][7:0]; byte i = bytes_i[i]
//   out_valid_o  out  1            bits_o holds a valid word
//   out_ready_i  in   1            downstream accepts bits_o this cycle
//   bits_o       out  N_BYTES*8    flattened bits
// BEHAVIOUR
//   - Mapping: bits_o[8*i+j] = bytes_i[i][j] for all i<N_BYTES, j<8; pure rewire, no reordering.
//   - Transfer in: in_valid_i && in_ready_o at a clock edge. Transfer out: out_valid_o && out_ready_i.
//   - Latency: a word accepted at edge k appears on bits_o with out_valid_o=1 after edge k.
//   - Storage: output register plus one skid register (2 entries total); FIFO order preserved.
//   - in_ready_o is a register output, driven only by state, never combinationally by out_ready_i;
//     it is 1 whenever the skid register is empty.
//   - Full throughput: with out_ready_i held 1, one word per cycle passes, no bubbles.
//   - Backpressure: while out_valid_o=1 and out_ready_i=0, bits_o and out_valid_o stay stable.
//     The next accepted word goes to the skid register and in_ready_o drops to 0.
//   - Drain: when the output register drains and the skid is full, skid moves to output on the
//     same edge; in_ready_o returns to 1 the cycle after.
//   - Simultaneous in and out transfer with one word held: the new word replaces the output
//     register; the skid stays empty.
//   - in_valid_i with in_ready_o=0 is ignored; the sender must hold the word.
//   - bytes_i is sampled only on accepted transfers. Unknown data bits must not corrupt valid flags.
//   - Reset (rst_i=1 at an edge, including mid-stream): out_valid_o=0, bits_o=0, skid cleared.
//     In-flight words are discarded. in_ready_o=0 while rst_i=1 and 1 on the first cycle after
//     reset is released.
//   - No internal arithmetic. Width is exactly N_BYTES*8. N_BYTES=1 reduces to an 8-bit register stage.
// TESTING
//   - pattern: bytes {EF,CD,AB,89} (byte0=EF) with out_ready_i=1 -> bits_o=32'h89ABCDEF, one cycle later.
//   - zeros/ones: all 00 -> 32'h00000000; all FF -> 32'hFFFFFFFF; incrementing {00,01,02,03} -> 32'h03020100.
//   - throughput: 5 pseudo-random words back-to-back, out_ready_i=1 -> 5 outputs in 5 consecutive
//     cycles, each equal to the LSB-first flatten of its input.
//   - backpressure: out_ready_i=0 for 3 cycles while sending 3 words -> 2 held, in_ready_o=0,
//     bits_o stable; release -> words emerge in order, none lost or duplicated.
//   - reset mid-stream: rst_i pulsed with 2 words held -> out_valid_o=0, bits_o=0;
//     in_ready_o=1 the cycle after release; next word passes normally.
//   - scoreboard: compare every output to the LSB-first flatten of its input, in order;
//     use case-equality (!==) on the comparison; pass/total summary at end.

Source files
------------

// File: rtl/bytes_to_bits_if.sv
// Valid/ready stream bundle for the byte-to-bit flattening stage.
// The slave modport is the stage itself; the master modport is the surrounding logic.
interface bytes_to_bits_if #(
    parameter int N_BYTES = 4
);
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [N_BYTES-1:0][7:0]  bytes_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [N_BYTES*8-1:0]     bits_o;

    modport slave (
        input  in_valid_i,
        output in_ready_o,
        input  bytes_i,
        output out_valid_o,
        input  out_ready_i,
        output bits_o
    );

    modport master (
        output in_valid_i,
        input  in_ready_o,
        output bytes_i,
        input  out_valid_o,
        output out_ready_i,
        input  bits_o
    );
endinterface

// File: rtl/bytes_to_bits.sv
// LSB-first byte-array to bit-vector flattening (ML-KEM BytesToBits order) as a
// registered valid/ready stage with a one-entry skid buffer.
module bytes_to_bits #(
    parameter int N_BYTES = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    bytes_to_bits_if.slave  bus
);
    localparam int W = N_BYTES * 8;

    logic [W-1:0] w_flat;

    logic [W-1:0] r_out_data;
    logic         r_out_vld;
    logic [W-1:0] r_skid_data;
    logic         r_skid_vld;
    logic         r_in_ready;

    logic [W-1:0] w_out_data_nxt;
    logic         w_out_vld_nxt;
    logic [W-1:0] w_skid_data_nxt;
    logic         w_skid_vld_nxt;
    logic         w_in_ready_nxt;

    logic         w_in_fire;
    logic         w_out_fire;

    // Bit j of byte i lands on flat bit 8*i+j.
    always_comb begin
        w_flat = '0;
        for (int i = 0; i < N_BYTES; i++) begin
            for (int j = 0; j < 8; j++) begin
                w_flat[8*i+j] = bus.bytes_i[i][j];
            end
        end
    end

    assign w_in_fire  = bus.in_valid_i && r_in_ready;
    assign w_out_fire = r_out_vld && bus.out_ready_i;

    always_comb begin
        w_out_data_nxt  = r_out_data;
        w_out_vld_nxt   = r_out_vld;
        w_skid_data_nxt = r_skid_data;
        w_skid_vld_nxt  = r_skid_vld;

        if (!r_out_vld || w_out_fire) begin
            // Output slot frees up: the skid has priority so FIFO order holds.
            // in_ready is low whenever the skid is full, so no input arrives then.
            if (r_skid_vld) begin
                w_out_data_nxt = r_skid_data;
                w_out_vld_nxt  = 1'b1;
                w_skid_vld_nxt = 1'b0;
            end else if (w_in_fire) begin
                w_out_data_nxt = w_flat;
                w_out_vld_nxt  = 1'b1;
            end else begin
                w_out_vld_nxt  = 1'b0;
            end
        end else if (w_in_fire) begin
            w_skid_data_nxt = w_flat;
            w_skid_vld_nxt  = 1'b1;
        end

        w_in_ready_nxt = !w_skid_vld_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_data  <= '0;
            r_out_vld   <= 1'b0;
            r_skid_data <= '0;
            r_skid_vld  <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_out_data  <= w_out_data_nxt;
            r_out_vld   <= w_out_vld_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_vld  <= w_skid_vld_nxt;
            r_in_ready  <= w_in_ready_nxt;
        end
    end

    assign bus.in_ready_o  = r_in_ready;
    assign bus.out_valid_o = r_out_vld;
    assign bus.bits_o      = r_out_data;
endmodule

// File: tb/tb_bytes_to_bits.sv
// Directed bench for bytes_to_bits: a depth-2 FIFO reference model checked every
// cycle, plus hand-computed literal expectations for the named scenarios.
module tb_bytes_to_bits;
    localparam int NB = 4;

    logic clk;
    logic rst;
    logic [7:0] cur [NB];

    bytes_to_bits_if #(.N_BYTES(NB)) bus ();

    bytes_to_bits #(.N_BYTES(NB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int tests;
    int fails;
    int dut_pops;

    logic [31:0] q [$];
    logic        m_ready;
    logic        m_zero;
    logic        started;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NB; i++) bus.bytes_i[i] = cur[i];
    end

    function automatic logic [31:0] model_flat(input logic [7:0] b [NB]);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < NB; i++) v = v + (32'(b[i]) << (8 * i));
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bytes(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        cur[0] = b0; cur[1] = b1; cur[2] = b2; cur[3] = b3;
    endtask

    // Inputs change just after each rising edge, so at the falling edge they are
    // exactly what the next rising edge will sample: check, then advance the model.
    initial begin
        started = 1'b0;
        m_ready = 1'b0;
        m_zero  = 1'b1;
        forever begin
            @(negedge clk);
            if (started) begin
                chk("in_ready", 32'(bus.in_ready_o), 32'(m_ready));
                chk("out_valid", 32'(bus.out_valid_o), 32'(q.size() > 0));
                if (q.size() > 0)
                    chk("bits_vs_model", bus.bits_o, q[0]);
                else if (m_zero)
                    chk("bits_zero", bus.bits_o, 32'd0);
            end
            if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) dut_pops++;
            if (rst) begin
                q.delete();
                m_ready = 1'b0;
                m_zero  = 1'b1;
                started = 1'b1;
            end else if (started) begin
                logic acc;
                acc = bus.in_valid_i && m_ready;
                if (bus.out_ready_i && q.size() > 0) void'(q.pop_front());
                if (acc) begin
                    q.push_back(model_flat(cur));
                    m_zero = 1'b0;
                end
                m_ready = (q.size() < 2);
            end
        end
    end

    initial begin
        logic [31:0] wa, wb, wc;
        tests    = 0;
        fails    = 0;
        dut_pops = 0;
        rst             = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        set_bytes(8'h00, 8'h00, 8'h00, 8'h00);

        // Reset state
        repeat (3) step();
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_bits", bus.bits_o, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(bus.in_ready_o), 32'd1);

        // Pattern, zeros, ones, incrementing
        bus.out_ready_i = 1'b1;
        set_bytes(8'hEF, 8'hCD, 8'hAB, 8'h89);
        chk("model_pin_pattern", model_flat(cur), 32'h89ABCDEF);
        bus.in_valid_i = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        chk("pattern_valid", 32'(bus.out_valid_o), 32'd1);
        chk("pattern_bits", bus.bits_o, 32'h89ABCDEF);
        step();
        chk("pattern_drained", 32'(bus.out_valid_o), 32'd0);

        set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
        bus.in_valid_i = 1'b1;
        step();
        chk("zeros_bits", bus.bits_o, 32'h00000000);
        chk("zeros_valid", 32'(bus.out_valid_o), 32'd1);
        set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        step();
        chk("ones_bits", bus.bits_o, 32'hFFFFFFFF);
        set_bytes(8'h00, 8'h01, 8'h02, 8'h03);
        chk("model_pin_incr", model_flat(cur), 32'h03020100);
        step();
        bus.in_valid_i = 1'b0;
        chk("incr_bits", bus.bits_o, 32'h03020100);
        step();

        // Throughput: 5 words back-to-back, one output per cycle
        bus.in_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            step();
            chk("tput_valid", 32'(bus.out_valid_o), 32'd1);
            chk("tput_ready", 32'(bus.in_ready_o), 32'd1);
            chk("tput_bits", bus.bits_o, model_flat(cur));
        end
        bus.in_valid_i = 1'b0;
        repeat (2) step();

        // Backpressure: A held in output, B in skid, C refused
        bus.out_ready_i = 1'b0;
        set_bytes(8'h11, 8'h22, 8'h33, 8'h44); wa = model_flat(cur);
        bus.in_valid_i = 1'b1;
        step();
        set_bytes(8'h55, 8'h66, 8'h77, 8'h88); wb = model_flat(cur);
        step();
        chk("bp_ready_drop", 32'(bus.in_ready_o), 32'd0);
        set_bytes(8'h99, 8'hAA, 8'hBB, 8'hCC); wc = model_flat(cur);
        step();
        chk("bp_hold_bits", bus.bits_o, 32'h44332211);
        chk("bp_hold_valid", 32'(bus.out_valid_o), 32'd1);
        chk("bp_ready_low", 32'(bus.in_ready_o), 32'd0);
        bus.out_ready_i = 1'b1;
        step();
        chk("bp_drain_b", bus.bits_o, 32'h88776655);
        chk("bp_ready_back", 32'(bus.in_ready_o), 32'd1);
        step();
        bus.in_valid_i = 1'b0;
        chk("bp_c", bus.bits_o, 32'hCCBBAA99);
        step();
        chk("bp_empty", 32'(bus.out_valid_o), 32'd0);
        chk("bp_model_words", wa ^ wb ^ wc, 32'h44332211 ^ 32'h88776655 ^ 32'hCCBBAA99);

        // Reset mid-stream with two words held
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        set_bytes(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        step();
        set_bytes(8'h01, 8'h23, 8'h45, 8'h67);
        step();
        bus.in_valid_i = 1'b0;
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("mid_rst_bits", bus.bits_o, 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready_o), 32'd0);
        rst = 1'b0;
        step();
        chk("mid_rel_ready", 32'(bus.in_ready_o), 32'd1);
        chk("mid_rel_valid", 32'(bus.out_valid_o), 32'd0);
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        set_bytes(8'h11, 8'h22, 8'h33, 8'h44);
        step();
        bus.in_valid_i = 1'b0;
        chk("after_rst_bits", bus.bits_o, 32'h44332211);
        chk("after_rst_valid", 32'(bus.out_valid_o), 32'd1);
        repeat (2) step();

        // 4 single words + 5 throughput + 3 backpressure + 1 post-reset; held words discarded
        chk("total_outputs", 32'(dut_pops), 32'd13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
